// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared state type and sizing helper for the chunked adder controller
package adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adder_cin.sv
// adder_cin: nbit combinational adder with carry-in and carry-out
module adder_cin #(
  parameter int nbit = 32
) (
  input  logic [nbit-1:0] a,
  input  logic [nbit-1:0] b,
  input  logic            cin,
  output logic [nbit-1:0] s,
  output logic            cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{nbit{1'b0}}, cin};
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide add/subtract sequenced LSB-first over one narrow adder
module adder_seq_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int nbit   = 32,
  parameter int nchunk = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [nbit*nchunk-1:0] a,
  input  logic [nbit*nchunk-1:0] b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [nbit*nchunk-1:0] s,
  output logic                   cout,
  output logic                   ovf
);
  localparam int w  = nbit * nchunk;
  localparam int iw = idx_w(nchunk);
  state_t          state, nxt;
  logic [iw-1:0]   idx;
  logic            c, rdy, accept, last, co;
  logic [w-1:0]    a_q, b_q;
  logic [nbit-1:0] sum;
  adder_cin #(.nbit(nbit)) u_add (
    .a   (a_q[idx*nbit +: nbit]),
    .b   (b_q[idx*nbit +: nbit]),
    .cin (c),
    .s   (sum),
    .cout(co)
  );
  assign in_ready  = rdy;
  assign out_valid = state == DONE;
  assign accept    = state == IDLE && in_valid && rdy;
  assign last      = idx == iw'(nchunk - 1);
  always_comb
    nxt = state == IDLE ? (accept ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  // Subtraction is a + ~b + 1: the inversion is folded into b_q and the +1 into the seed carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      idx   <= '0;
      c     <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= nxt;
      rdy   <= nxt == IDLE;
      if (accept) begin
        a_q <= a;
        b_q <= sub ? ~b : b;
        c   <= sub;
        idx <= '0;
      end else if (state == RUN) begin
        s[idx*nbit +: nbit] <= sum;
        c   <= co;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout <= co;
          ovf  <= (a_q[w-1] == b_q[w-1]) && (sum[nbit-1] != a_q[w-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed vector bench for the chunked adder controller
module tb_adder_seq_ctrl;
  localparam int nbit = 8, nchunk = 4, w = 32;
  typedef struct {
    logic [31:0] a, b;
    logic        sub, early;
    logic [31:0] s;
    logic        cout, ovf;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, cout, ovf;
  logic [w-1:0] a = '0, b = '0, s;
  int n_vec = 0, n_bad = 0;
  vec_t tv[7];
  adder_seq_ctrl #(.nbit(nbit), .nchunk(nchunk)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
  endtask
  task automatic handshake(input string nm);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, " ready_back"}, 32'(in_ready), 32'd1);
  endtask
  task automatic apply(input vec_t v, input string nm);
    int cnt;
    a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    out_ready = v.early;
    chk({nm, " busy"}, 32'(in_ready), 32'd0);
    wait_valid(cnt);
    chk({nm, " latency"}, 32'(cnt), 32'd4);
    chk({nm, " s"}, s, v.s);
    chk({nm, " cout"}, 32'(cout), 32'(v.cout));
    chk({nm, " ovf"}, 32'(ovf), 32'(v.ovf));
    handshake(nm);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt;
    logic seen;
    tv[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tv[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tv[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    tv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
    tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 32'hACF1_3568, 1'b0, 1'b0};
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst s", s, 32'd0);
    chk("rst cout_ovf", {30'd0, cout, ovf}, 32'd0);
    #11 rst_n = 1'b1;
    #1 chk("ready before edge", 32'(in_ready), 32'd0);
    step();
    chk("ready first edge", 32'(in_ready), 32'd1);
    for (int i = 0; i < 7; i++) apply(tv[i], $sformatf("vec%0d", i));
    // Backpressure: result must hold while a new request waits at the input.
    a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1;
    step();
    a = 32'h0000_0007; b = 32'h0000_0005; sub = 1'b1;
    wait_valid(cnt);
    chk("bp latency", 32'(cnt), 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp valid", 32'(out_valid), 32'd1);
      chk("bp s", s, 32'h0000_0100);
      chk("bp flags", {30'd0, cout, ovf}, 32'd0);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    handshake("bp");
    step();
    in_valid = 1'b0;
    chk("bp accepted", 32'(in_ready), 32'd0);
    wait_valid(cnt);
    chk("bp2 latency", 32'(cnt), 32'd4);
    chk("bp2 s", s, 32'h0000_0002);
    chk("bp2 cout", 32'(cout), 32'd1);
    handshake("bp2");
    // Abort in the middle of the chunk sequence.
    a = 32'h0101_0101; b = 32'h0202_0202; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort s", s, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort ready low", 32'(in_ready), 32'd0);
    step();
    chk("abort ready edge", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid;
    end
    chk("abort no result", 32'(seen), 32'd0);
    apply(tv[6], "post_abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
